// File: rtl/phy_tx_pkg.sv
// ============================================================================
// Module      : phy_tx_pkg
// Description : Shared types and constants for the PHY transmit byte path.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package phy_tx_pkg;

    localparam int LANES = 4;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // K28.5 comma, the line filler between frames
    localparam logic [7:0] COM_SYMBOL = 8'hBC;

endpackage

`default_nettype wire

// File: rtl/tx_group_stage.sv
// ============================================================================
// Module      : tx_group_stage
// Description : One-group staging buffer with ready/take handshake logic.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tx_group_stage
    import phy_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [LANES-1:0][WIDTH-1:0]   i_data,
    input  logic [LANES-1:0]              i_valid,
    input  logic                          i_load,
    input  logic                          i_can_take,
    output logic [LANES-1:0][WIDTH-1:0]   o_stage_data,
    output logic [LANES-1:0]              o_stage_valid,
    output logic                          o_stage_full,
    output logic                          o_ready,
    output logic                          o_take
);

    logic [LANES-1:0][WIDTH-1:0] r_data;
    logic [LANES-1:0]            r_valid;
    logic                        r_full;
    logic                        w_take;
    logic                        w_ready;
    logic                        w_accept;

    // The stage frees up in the same cycle it is taken, so a refill can land
    // on that edge and back-to-back groups stay gapless.
    assign w_take   = r_full && i_can_take;
    assign w_ready  = !r_full || w_take;
    assign w_accept = i_load && w_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= '0;
            r_full  <= 1'b0;
        end else if (w_accept) begin
            r_data  <= i_data;
            r_valid <= i_valid;
            r_full  <= 1'b1;
        end else if (w_take) begin
            r_full  <= 1'b0;
        end
    end

    assign o_stage_data  = r_data;
    assign o_stage_valid = r_valid;
    assign o_stage_full  = r_full;
    assign o_ready       = w_ready;
    assign o_take        = w_take;

endmodule

`default_nettype wire

// File: rtl/mux_4x1_8bits_tx.sv
// ============================================================================
// Module      : mux_4x1_8bits_tx
// Description : Serialises 4-lane byte groups onto one byte stream, lane 0
//               first. Define IDLE_FILL_EN to drive IDLE_SYMBOL on idle bytes.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_4x1_8bits_tx
    import phy_tx_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] IDLE_SYMBOL = COM_SYMBOL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in0,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic [WIDTH-1:0] data_in3,
    input  logic             valid_in0,
    input  logic             valid_in1,
    input  logic             valid_in2,
    input  logic             valid_in3,
    input  logic             load,
    output logic             ready_out,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [1:0]       lane_sel,
    output logic             busy
);

    localparam logic [0:0] ST_IDLE = 1'(IDLE);
    localparam logic [0:0] ST_SEND = 1'(SEND);

`ifdef IDLE_FILL_EN
    localparam logic c_fill_en = 1'b1;
`else
    localparam logic c_fill_en = 1'b0;
`endif
    localparam logic [WIDTH-1:0] c_fill_byte = c_fill_en ? IDLE_SYMBOL : '0;

    logic [LANES-1:0][WIDTH-1:0] w_stage_data;
    logic [LANES-1:0]            w_stage_valid;
    logic                        w_stage_full;
    logic                        w_take;
    logic                        w_can_take;

    logic [LANES-1:0][WIDTH-1:0] r_active_data;
    logic [LANES-1:0]            r_active_valid;
    logic [0:0]                  r_state;
    lane_idx_t                   r_cnt;
    logic [WIDTH-1:0]            r_data_out;
    logic                        r_valid_out;
    lane_idx_t                   r_lane_sel;

    assign w_can_take = (r_state == ST_IDLE) || (r_cnt == '0);

    tx_group_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk           (clk),
        .reset         (reset),
        .i_data        ({data_in3, data_in2, data_in1, data_in0}),
        .i_valid       ({valid_in3, valid_in2, valid_in1, valid_in0}),
        .i_load        (load),
        .i_can_take    (w_can_take),
        .o_stage_data  (w_stage_data),
        .o_stage_valid (w_stage_valid),
        .o_stage_full  (w_stage_full),
        .o_ready       (ready_out),
        .o_take        (w_take)
    );

    // r_cnt is the next lane to emit; 0 in SEND means the group is finished.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_active_data  <= '0;
            r_active_valid <= '0;
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_data_out     <= c_fill_byte;
            r_valid_out    <= 1'b0;
            r_lane_sel     <= '0;
        end else if (w_take) begin
            r_active_data  <= w_stage_data;
            r_active_valid <= w_stage_valid;
            r_data_out     <= w_stage_valid[0] ? w_stage_data[0] : c_fill_byte;
            r_valid_out    <= w_stage_valid[0];
            r_lane_sel     <= '0;
            r_cnt          <= lane_idx_t'(1);
            r_state        <= ST_SEND;
        end else if ((r_state == ST_SEND) && (r_cnt != '0)) begin
            r_data_out     <= r_active_valid[r_cnt] ? r_active_data[r_cnt] : c_fill_byte;
            r_valid_out    <= r_active_valid[r_cnt];
            r_lane_sel     <= r_cnt;
            r_cnt          <= r_cnt + lane_idx_t'(1);
        end else begin
            r_state        <= ST_IDLE;
            r_data_out     <= c_fill_byte;
            r_valid_out    <= 1'b0;
            r_lane_sel     <= '0;
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign lane_sel  = r_lane_sel;
    assign busy      = (r_state == ST_SEND) || w_stage_full;

endmodule

`default_nettype wire
